// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin scheduler that shares one iterative shift-add
// multiplier among N_REQ requesters. The winner's operands are latched, the
// multiplier is sequenced through clear/load/run, and the truncated product
// is returned with a one-cycle ack to the winning requester.
//
// Optional build macro MUL_ARB_ZERO_BYPASS_EN: when defined, a grant whose
// A or B operand is zero skips the multiplier and completes with result 0
// two cycles after the request is sampled.
module mul_arbiter #(
   parameter int N_BITS = 32,
   parameter int N_REQ  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*N_BITS-1:0]   a_in,
   input  logic [N_REQ*N_BITS-1:0]   b_in,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          ack,
   output logic [N_BITS-1:0]         result,
   output logic                      busy,
   output logic [N_BITS-1:0]         mul_a,
   output logic [N_BITS-1:0]         mul_b,
   output logic                      mul_start,
   output logic                      mul_rst,
   input  logic [N_BITS-1:0]         mul_out
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [PW-1:0]       ptr;
   logic [CW-1:0]       cnt;

   logic [PW:0]         shamt;
   logic [2*N_REQ-1:0]  req_rot_full;
   logic [N_REQ-1:0]    req_rot;
   int                  sel_sum;
   logic                win_found;
   logic [PW-1:0]       win_idx;
   logic [N_BITS-1:0]   win_a;
   logic [N_BITS-1:0]   win_b;
   logic                skip;

`ifdef MUL_ARB_ZERO_BYPASS_EN
   logic                bypass;
`endif

   // Round-robin pick: rotate requests so the one after the last winner is bit 0.
   always_comb begin
      shamt        = {1'b0, ptr} + {{PW{1'b0}}, 1'b1};
      req_rot_full = {req, req} >> shamt;
      req_rot      = req_rot_full[N_REQ-1:0];
      win_found    = 1'b0;
      sel_sum      = 0;
      // Scan downward so the lowest rotated position (closest to ptr+1) wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         win_found = win_found | req_rot[k];
         sel_sum   = req_rot[k] ? (int'(ptr) + 1 + k) : sel_sum;
      end
      sel_sum = (sel_sum >= N_REQ) ? (sel_sum - N_REQ) : sel_sum;
      win_idx = PW'(sel_sum);
      win_a   = a_in[win_idx*N_BITS +: N_BITS];
      win_b   = b_in[win_idx*N_BITS +: N_BITS];
`ifdef MUL_ARB_ZERO_BYPASS_EN
      skip    = (win_a == {N_BITS{1'b0}}) || (win_b == {N_BITS{1'b0}});
`else
      skip    = 1'b0;
`endif
   end

   // State register; reset returns the sequencer to IDLE from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode for the clear/load/run sequence.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (win_found) begin
               next_state = skip ? DONE : CLEAR;
            end else begin
               next_state = IDLE;
            end
         end
         CLEAR: next_state = LOAD;
         LOAD:  next_state = RUN;
         RUN: begin
            if (cnt == CNT_LAST) begin
               next_state = DONE;
            end else begin
               next_state = RUN;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: grant/operand latch, step counter, result capture and ack pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= '0;
         ack       <= '0;
         result    <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_start <= 1'b0;
         cnt       <= '0;
         ptr       <= PTR_INIT;
`ifdef MUL_ARB_ZERO_BYPASS_EN
         bypass    <= 1'b0;
`endif
      end else begin
         ack       <= '0;
         mul_start <= (next_state == LOAD);
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant  <= ONE_HOT0 << win_idx;
                  mul_a  <= win_a;
                  mul_b  <= win_b;
                  ptr    <= win_idx;
`ifdef MUL_ARB_ZERO_BYPASS_EN
                  bypass <= skip;
`endif
               end
               cnt <= '0;
            end
            RUN: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
`ifdef MUL_ARB_ZERO_BYPASS_EN
               result <= bypass ? {N_BITS{1'b0}} : mul_out;
`else
               result <= mul_out;
`endif
               ack    <= grant;
               grant  <= '0;
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

   // Multiplier is held in reset during rst and for the single CLEAR cycle.
   assign mul_rst = rst | (state == CLEAR);
   assign busy    = (state != IDLE);

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin scheduler that shares one iterative shift-add multiplier (`mul`, N_BITS-wide, rising-edge `start`, one bit per cycle) among N_REQ requesters in the stepper driver, e.g. speed/accel scaling and microstep current calculation.
- Latches the winner's operands and sequences the multiplier through clear/load/run.
- Returns the truncated product with a one-cycle ack to the winning requester.

Parameters:
- N_BITS, 32, operand and product width; must equal the multiplier's N_BITS.
- N_REQ, 3, number of requesters, 2..8.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  level request per requester
- a_in  input  N_REQ*N_BITS  operand A; requester i at bits [i*N_BITS +: N_BITS]
- b_in  input  N_REQ*N_BITS  operand B; same packing as a_in
- grant  output  N_REQ  one-hot; current owner, zero when idle
- ack  output  N_REQ  one-hot, single-cycle; result valid for that requester
- result  output  N_BITS  product, valid while ack is nonzero
- busy  output  1  high when state is not IDLE
- mul_a  output  N_BITS  multiplier operand A
- mul_b  output  N_BITS  multiplier operand B
- mul_start  output  1  multiplier start
- mul_rst  output  1  multiplier reset
- mul_out  input  N_BITS  multiplier product

Behaviour:
- Reset values:
  - Registers: grant=0, ack=0, result=0, mul_a=0, mul_b=0, mul_start=0, state=IDLE, step counter=0, last-grant pointer=N_REQ-1 (requester 0 wins first).
  - mul_rst = rst OR (state==CLEAR); combinational.
  - busy is decoded from state.
- FSM: IDLE -> CLEAR -> LOAD -> RUN -> DONE -> IDLE.
- IDLE, any req high:
  - Pick the first set req scanning upward from pointer+1, modulo N_REQ.
  - Register grant, the winner's a/b into mul_a/mul_b, and pointer=winner.
  - Go to CLEAR.
- IDLE, no req: stay; ack clears.
- CLEAR: mul_rst=1, mul_start=0 for exactly one cycle. This guarantees the multiplier's busy is low before the load edge.
- LOAD: mul_start=1 for one cycle. The multiplier captures operands at the end of this cycle.
- RUN:
  - mul_start=0.
  - Counter counts 0..N_BITS-1, one cycle each, so the multiplier performs N_BITS steps.
  - After count N_BITS-1, go to DONE.
- DONE:
  - result <= mul_out; ack <= grant; grant <= 0; return to IDLE.
  - ack is high for exactly the following cycle only.
- Latency: req sampled in IDLE at cycle 0 -> ack/result at cycle N_BITS+4.
  - In the ack cycle the FSM is already in IDLE and may grant the next request, so back-to-back throughput is one op per N_BITS+4 cycles.
- Arithmetic: product is truncated to the low N_BITS; no overflow flag.
- Operands are latched at grant; later a_in/b_in changes have no effect on the current op.
- req dropped after grant: the op still completes and ack still pulses to the original owner.
- req dropped before sampling in IDLE: not served.
- Simultaneous reqs: round-robin per the pointer; a continuously asserted req is served within N_REQ ops.
- rst in any state:
  - FSM returns to IDLE next edge.
  - Outputs return to reset values and the pointer resets.
  - No ack for the aborted op.
  - mul_rst is high during rst.
- mul_a/mul_b hold their value until the next grant.

Optional Feature:
- Macro: MUL_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's a or b is 0:
  - grant is registered and the FSM goes directly to DONE; CLEAR/LOAD/RUN are skipped and the multiplier is not started.
  - DONE writes result=0 (not mul_out).
  - ack arrives at cycle 2; the pointer updates as normal.
- Undefined: zero operands take the full N_BITS+4 path with result 0.

Test Plan:
- N_BITS=32, N_REQ=3. req[0] held with a=7, b=6 -> ack=3'b001 at cycle 36, result=42; grant=3'b001 during cycles 1..35; busy low at cycle 36.
- req[1] with a=0x0001_0000, b=0x0001_0000 -> result=0 (truncated). With a=0xFFFF_FFFF, b=2 -> result=0xFFFF_FFFE.
- req=3'b111 held from reset, a_i=i+1, b_i=10 -> acks in order 001, 010, 100 at cycles 36, 72, 108; results 10, 20, 30.
- After req[0] is served, hold req[0] and req[2] continuously -> grant order 100, 001, 100, 001; req[1] is never granted.
- Assert rst for one cycle during RUN (cycle 20) -> next cycle: grant=0, busy=0, no ack. A subsequent req[2] alone is served with a correct product (pointer reset verified by granting req[0] first when req=3'b101).
- With MUL_ARB_ZERO_BYPASS_EN defined, req[0] with a=0, b=5 -> ack=3'b001 at cycle 2, result=0, mul_start never high. Without the macro -> ack at cycle 36, result=0.
